// File: rtl/cipher_core_mc.sv
// cipher_core_mc
// Multi-channel ECB/CTR controller that sits between a stream interface and
// external encrypt/decrypt round pipelines of fixed latency LAT.
//
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   vin/tin/cin/din  input beat: valid, type (00 ENC, 01 DEC, 10 KEY, 11 IV),
//                    channel, data
//   keyed          key expansion complete; arms the core once
//   crypto_mode    0 ECB, 1 CTR; latched when the core arms
//   crypto_ready   core armed
//   eng_din        block presented to both engines (combinational)
//   enc_dout/dec_dout  engine results, LAT cycles after eng_din
//   vout/tout/cout/dout  output beat: valid, type (0 ENC, 1 DEC), channel, data
//   wrap_err       sticky per-channel counter-wrap flags
module cipher_core_mc #(
  parameter int DATA_W = 128,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int CTR_W  = 32,
  parameter int LAT    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vin,
  input  logic [1:0]        tin,
  input  logic [CH_W-1:0]   cin,
  input  logic [DATA_W-1:0] din,
  input  logic              keyed,
  input  logic              crypto_mode,
  output logic              crypto_ready,
  output logic [DATA_W-1:0] eng_din,
  input  logic [DATA_W-1:0] enc_dout,
  input  logic [DATA_W-1:0] dec_dout,
  output logic              vout,
  output logic              tout,
  output logic [CH_W-1:0]   cout,
  output logic [DATA_W-1:0] dout,
  output logic [NUM_CH-1:0] wrap_err
);

  localparam logic [1:0] T_ENC = 2'b00;
  localparam logic [1:0] T_DEC = 2'b01;
  localparam logic [1:0] T_IV  = 2'b11;

  logic              mode;
  logic [DATA_W-1:0] enc_ctr [NUM_CH];
  logic [DATA_W-1:0] dec_ctr [NUM_CH];

  logic              accept;
  logic              iv_load;
  logic [DATA_W-1:0] sel_ctr;
  logic [DATA_W-1:0] next_ctr;
  logic              wrap_hit;

  // control pipeline, aligned with the external engine latency
  logic              pv [LAT];
  logic              pt [LAT];
  logic [CH_W-1:0]   pc [LAT];
  logic [DATA_W-1:0] pp [LAT];

  // Beat qualification, counter selection/increment and engine input mux.
  always_comb begin
    accept   = 1'b0;
    iv_load  = 1'b0;
    sel_ctr  = '0;
    next_ctr = '0;
    wrap_hit = 1'b0;
    eng_din  = '0;

    accept  = vin && crypto_ready && ((tin == T_ENC) || (tin == T_DEC));
    iv_load = vin && (tin == T_IV);

    if (tin == T_DEC) begin
      sel_ctr = dec_ctr[cin];
    end else begin
      sel_ctr = enc_ctr[cin];
    end

    // only the low CTR_W bits count; the upper part is a fixed nonce
    next_ctr              = sel_ctr;
    next_ctr[CTR_W-1:0]   = sel_ctr[CTR_W-1:0] + {{(CTR_W-1){1'b0}}, 1'b1};
    wrap_hit              = &sel_ctr[CTR_W-1:0];

    if (accept) begin
      if (mode) begin
        eng_din = sel_ctr;
      end else begin
        eng_din = din;
      end
    end else begin
      eng_din = '0;
    end
  end

  // Arming, mode latch, per-channel counters and sticky wrap flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crypto_ready <= 1'b0;
      mode         <= 1'b0;
      wrap_err     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        enc_ctr[i] <= '0;
        dec_ctr[i] <= '0;
      end
    end else begin
      if (keyed && !crypto_ready) begin
        crypto_ready <= 1'b1;
        mode         <= crypto_mode;
      end

      if (iv_load) begin
        enc_ctr[cin]  <= din;
        dec_ctr[cin]  <= din;
        wrap_err[cin] <= 1'b0;
      end else if (accept && mode) begin
        if (tin == T_DEC) begin
          dec_ctr[cin] <= next_ctr;
        end else begin
          enc_ctr[cin] <= next_ctr;
        end
        if (wrap_hit) begin
          wrap_err[cin] <= 1'b1;
        end
      end
    end
  end

  // Control pipeline shift; idle stages carry zeros so the exit fields are clean.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] <= 1'b0;
        pt[i] <= 1'b0;
        pc[i] <= '0;
        pp[i] <= '0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pt[i] <= pt[i-1];
        pc[i] <= pc[i-1];
        pp[i] <= pp[i-1];
      end
      if (accept) begin
        pv[0] <= 1'b1;
        pt[0] <= tin[0];
        pc[0] <= cin;
        pp[0] <= mode ? din : '0;
      end else begin
        pv[0] <= 1'b0;
        pt[0] <= 1'b0;
        pc[0] <= '0;
        pp[0] <= '0;
      end
    end
  end

  // Output register: combine engine result with the realigned control stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vout <= 1'b0;
      tout <= 1'b0;
      cout <= '0;
      dout <= '0;
    end else begin
      vout <= pv[LAT-1];
      tout <= pt[LAT-1];
      cout <= pc[LAT-1];
      if (pv[LAT-1]) begin
        if (mode) begin
          // CTR decrypt also uses the encrypt engine on the counter block
          dout <= enc_dout ^ pp[LAT-1];
        end else if (pt[LAT-1]) begin
          dout <= dec_dout;
        end else begin
          dout <= enc_dout;
        end
      end else begin
        dout <= '0;
      end
    end
  end

endmodule
